// File: rtl/ysyx_22050612_wb_arbiter_if.sv
// Writeback request bus between the three result producers (EXU, LSU, CSR) and the arbiter.
// A transfer happens on requester i in any cycle where wb_valid[i] && wb_ready[i]. wb_ready depends only on wb_valid and the arbiter's pointer. A requester left waiting keeps its addr/data stable.
interface ysyx_22050612_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  logic [2:0]              wb_valid;
  logic [2:0]              wb_ready;
  logic [3*ADDR_WIDTH-1:0] wb_addr;
  logic [3*DATA_WIDTH-1:0] wb_data;

  modport master (output wb_valid, wb_addr, wb_data, input wb_ready);
  modport slave  (input wb_valid, wb_addr, wb_data, output wb_ready);
endinterface

// File: rtl/ysyx_22050612_wb_arbiter.sv
// Round-robin writeback arbiter for three producers into one register-file write port,
// plus a per-register busy scoreboard used for issue-side hazard detection.
module ysyx_22050612_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ysyx_22050612_wb_arbiter_if.slave wb,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [1:0]            ptr_dbg
);

  localparam int NREG = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    PTR_EXU = 2'd0,
    PTR_LSU = 2'd1,
    PTR_CSR = 2'd2
  } ptr_t;

  ptr_t                  ptr_q, ptr_n;
  logic [2:0]            grant;
  logic                  any_grant;
  logic [1:0]            gidx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NREG-1:0]       busy_q, busy_n;

  // (base + off) mod 3 for base, off in {0,1,2}
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PTR_EXU;
    else        ptr_q <= ptr_n;
  end

  always_comb begin
    any_grant   = 1'b0;
    gidx        = 2'd0;
    grant       = '0;
    ptr_n       = ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!any_grant && wb.wb_valid[rr_idx(ptr_q, 2'(k))]) begin
        any_grant = 1'b1;
        gidx      = rr_idx(ptr_q, 2'(k));
      end
    end
    if (any_grant) begin
      grant = 3'b001 << gidx;
      ptr_n = ptr_t'(rr_idx(gidx, 2'd1));
    end
    wb.wb_ready = rst_n ? grant : 3'b000;
  end

  always_comb begin
    sel_addr = wb.wb_addr[0 +: ADDR_WIDTH];
    sel_data = wb.wb_data[0 +: DATA_WIDTH];
    case (gidx)
      2'd1: begin
        sel_addr = wb.wb_addr[ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = wb.wb_data[DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        sel_addr = wb.wb_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = wb.wb_data[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: ;
    endcase
  end

  // x0 writes complete the handshake but never reach the register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= any_grant && (sel_addr != '0);
      if (any_grant) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  // Set after clear so a newly issued producer wins over a retiring one.
  always_comb begin
    busy_n = busy_q;
    if (rf_wen) busy_n[rf_waddr] = 1'b0;
    if (iss_valid && iss_rd != '0) busy_n[iss_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_n;
  end

  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
  assign ptr_dbg  = ptr_q;

endmodule

// File: tb/tb_ysyx_22050612_wb_arbiter.sv
// Bench for the writeback arbiter: table vectors, hand sequences for scoreboard and reset corners,
// and a random phase checked against a small round-robin/scoreboard model.
module tb_ysyx_22050612_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int EW = 1 + AW + DW;

  typedef struct packed {
    logic [2:0]    v;
    logic [AW-1:0] a0, a1, a2;
    logic [DW-1:0] d0, d1, d2;
    logic          iv;
    logic [AW-1:0] ird;
    logic [2:0]    rdy;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          iss_valid;
  logic [AW-1:0] iss_rd, rs1, rs2;
  logic          rs1_busy, rs2_busy;
  logic [1:0]    ptr_dbg;

  ysyx_22050612_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wbif ();

  ysyx_22050612_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb       (wbif.slave),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .ptr_dbg  (ptr_dbg)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [EW-1:0] exp_q[$];
  int            m_ptr;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [31:0]   busy_m;
  vec_t          tbl[12];
  vec_t          rv;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [AW-1:0] a2, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [DW-1:0] d2, input logic iv, input logic [AW-1:0] ird,
                              input logic [2:0] rdy);
    vec_t t;
    t.v = v; t.a0 = a0; t.a1 = a1; t.a2 = a2;
    t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.iv = iv; t.ird = ird; t.rdy = rdy;
    return t;
  endfunction

  function automatic logic [2:0] arb_model(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (p + k) % 3;
      if (v[i]) return 3'b001 << i;
    end
    return 3'b000;
  endfunction

  // One bus cycle: check last edge's outputs, drive t, check combinational outputs, predict next edge.
  task automatic cycle(input vec_t t);
    logic [EW-1:0] e;
    logic          wen;
    int            idx;
    @(negedge clk);
    check("ptr", 64'(ptr_dbg), 64'(m_ptr));
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL rf_queue: got empty expected one entry at %0t", $time);
      e = '0;
    end else begin
      e = exp_q.pop_front();
      check("rf_wen", 64'(rf_wen), 64'(e[EW-1]));
      check("rf_waddr", 64'(rf_waddr), 64'(e[DW +: AW]));
      check("rf_wdata", rf_wdata, e[DW-1:0]);
    end
    wbif.wb_valid = t.v;
    wbif.wb_addr  = {t.a2, t.a1, t.a0};
    wbif.wb_data  = {t.d2, t.d1, t.d0};
    iss_valid     = t.iv;
    iss_rd        = t.ird;
    #1;
    check("wb_ready", 64'(wbif.wb_ready), 64'(t.rdy));
    check("rs1_busy", 64'(rs1_busy), 64'(busy_m[rs1]));
    check("rs2_busy", 64'(rs2_busy), 64'(busy_m[rs2]));
    wen = 1'b0;
    if (t.rdy != 3'b000) begin
      idx     = t.rdy[0] ? 0 : (t.rdy[1] ? 1 : 2);
      m_waddr = (idx == 0) ? t.a0 : ((idx == 1) ? t.a1 : t.a2);
      m_wdata = (idx == 0) ? t.d0 : ((idx == 1) ? t.d1 : t.d2);
      wen     = (m_waddr != '0);
      m_ptr   = (idx + 1) % 3;
    end
    exp_q.push_back({wen, m_waddr, m_wdata});
    if (e[EW-1]) busy_m[e[DW +: AW]] = 1'b0;
    if (t.iv && t.ird != '0) busy_m[t.ird] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    wbif.wb_valid = 3'b111;
    iss_valid     = 1'b0;
    #2;
    check("rst_ready", 64'(wbif.wb_ready), 64'd0);
    check("rst_rf_wen", 64'(rf_wen), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", rf_wdata, 64'd0);
    check("rst_ptr", 64'(ptr_dbg), 64'd0);
    check("rst_rs1_busy", 64'(rs1_busy), 64'd0);
    check("rst_rs2_busy", 64'(rs2_busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_hold", 64'(wbif.wb_ready), 64'd0);
    @(negedge clk);
    wbif.wb_valid = 3'b000;
    rst_n         = 1'b1;
    exp_q.delete();
    exp_q.push_back('0);
    m_ptr   = 0;
    m_waddr = '0;
    m_wdata = '0;
    busy_m  = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = mk(3'b010, '0, 5'd5, '0, '0, 64'hAB, '0, 1'b0, '0, 3'b010);
    tbl[1]  = mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b0, '0, 3'b000);
    tbl[2]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33, 1'b0, '0, 3'b100);
    tbl[3]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33, 1'b0, '0, 3'b001);
    tbl[4]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33, 1'b0, '0, 3'b010);
    tbl[5]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33, 1'b0, '0, 3'b100);
    tbl[6]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33, 1'b0, '0, 3'b001);
    tbl[7]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33, 1'b0, '0, 3'b010);
    tbl[8]  = mk(3'b001, 5'd0, '0, '0, 64'hFF, '0, '0, 1'b0, '0, 3'b001);
    tbl[9]  = mk(3'b101, 5'd8, '0, 5'd9, 64'h88, '0, 64'h99, 1'b0, '0, 3'b100);
    tbl[10] = mk(3'b101, 5'd8, '0, 5'd9, 64'h88, '0, 64'h99, 1'b0, '0, 3'b001);
    tbl[11] = mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b0, '0, 3'b000);

    wbif.wb_valid = 3'b000;
    wbif.wb_addr  = '0;
    wbif.wb_data  = '0;
    iss_valid     = 1'b0;
    iss_rd        = '0;
    rs1           = '0;
    rs2           = '0;
    #1;
    do_reset();

    for (int i = 0; i < 12; i++) cycle(tbl[i]);

    // Issue to x7, LSU retires it; busy must drop only after the rf_wen cycle.
    rs1 = 5'd7;
    cycle(mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b1, 5'd7, 3'b000));
    cycle(mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b0, '0, 3'b000));
    cycle(mk(3'b010, '0, 5'd7, '0, '0, 64'h77, '0, 1'b0, '0, 3'b010));
    cycle(mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b0, '0, 3'b000));
    cycle(mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b0, '0, 3'b000));

    // Retire and re-issue x3 on the same edge: x3 stays busy.
    rs2 = 5'd3;
    cycle(mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b1, 5'd3, 3'b000));
    cycle(mk(3'b001, 5'd3, '0, '0, 64'h33, '0, '0, 1'b0, '0, 3'b001));
    cycle(mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b1, 5'd3, 3'b000));
    cycle(mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b0, '0, 3'b000));
    cycle(mk(3'b010, '0, 5'd3, '0, '0, 64'h3C, '0, 1'b0, '0, 3'b010));
    cycle(mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b0, '0, 3'b000));
    cycle(mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b0, '0, 3'b000));

    for (int i = 0; i < 40; i++) begin
      rs1    = AW'($urandom_range(0, 31));
      rs2    = AW'($urandom_range(0, 31));
      rv.v   = 3'($urandom_range(0, 7));
      rv.a0  = AW'($urandom_range(0, 31));
      rv.a1  = AW'($urandom_range(0, 31));
      rv.a2  = AW'($urandom_range(0, 31));
      rv.d0  = {32'($urandom), 32'($urandom)};
      rv.d1  = {32'($urandom), 32'($urandom)};
      rv.d2  = {32'($urandom), 32'($urandom)};
      rv.iv  = 1'($urandom_range(0, 1));
      rv.ird = AW'($urandom_range(0, 31));
      rv.rdy = arb_model(rv.v, m_ptr);
      cycle(rv);
    end

    // Reset arrives while CSR holds the grant; that grant must be discarded.
    rs1 = 5'd9;
    rs2 = 5'd0;
    cycle(mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b1, 5'd9, 3'b000));
    cycle(mk(3'b100, '0, '0, 5'd12, '0, '0, 64'hC5, 1'b0, '0, 3'b100));
    do_reset();

    cycle(mk(3'b111, 5'd4, 5'd5, 5'd6, 64'h44, 64'h55, 64'h66, 1'b0, '0, 3'b001));
    cycle(mk(3'b111, 5'd4, 5'd5, 5'd6, 64'h44, 64'h55, 64'h66, 1'b0, '0, 3'b010));
    cycle(mk(3'b111, 5'd4, 5'd5, 5'd6, 64'h44, 64'h55, 64'h66, 1'b0, '0, 3'b100));
    cycle(mk(3'b111, 5'd4, 5'd5, 5'd6, 64'h44, 64'h55, 64'h66, 1'b0, '0, 3'b001));
    cycle(mk(3'b111, 5'd4, 5'd5, 5'd6, 64'h44, 64'h55, 64'h66, 1'b0, '0, 3'b010));
    cycle(mk(3'b111, 5'd4, 5'd5, 5'd6, 64'h44, 64'h55, 64'h66, 1'b0, '0, 3'b100));
    cycle(mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b0, '0, 3'b000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_22050612_wb_arbiter.md
YSYX_22050612_WB_ARBITER -- requirements
Module: ysyx_22050612_wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register-index width.
REQ-002 Parameter DATA_WIDTH, default 64, register data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wb_valid  input  3  per-requester writeback request; bit 0 EXU, bit 1 LSU, bit 2 CSR.
REQ-006 wb_ready  output  3  per-requester grant, one-hot or zero.
REQ-007 wb_addr  input  3*ADDR_WIDTH  destination index; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 wb_data  input  3*DATA_WIDTH  write data; requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 rf_wen  output  1  registered write enable to the register file.
REQ-010 rf_waddr  output  ADDR_WIDTH  registered write index.
REQ-011 rf_wdata  output  DATA_WIDTH  registered write data.
REQ-012 iss_valid  input  1  an instruction with destination iss_rd issues this cycle.
REQ-013 iss_rd  input  ADDR_WIDTH  destination index of the issuing instruction.
REQ-014 rs1, rs2  input  ADDR_WIDTH each  source indices to check for hazards.
REQ-015 rs1_busy, rs2_busy  output  1 each  combinational: source has a pending write.

Function
REQ-016 Handshake: transfer on requester i when wb_valid[i] && wb_ready[i]; wb_ready depends combinationally on wb_valid and the priority pointer only (never on wb_data/wb_addr).
REQ-017 At most one wb_ready bit high per cycle; if any wb_valid is high, exactly one is granted (no idle cycles while a request is pending).
REQ-018 Round-robin: 2-bit pointer ptr in {0,1,2}; search order ptr, ptr+1, ptr+2 (mod 3); first valid is granted.
REQ-019 After a grant to i, ptr <= (i+1) mod 3; with no grant, ptr holds.
REQ-020 Latency: grant in cycle N -> rf_wen/rf_waddr/rf_wdata present in cycle N+1, held for exactly one cycle.
REQ-021 Granted write to index 0: handshake completes; rf_wen = 0 in N+1 (x0 suppression).
REQ-022 No grant in cycle N -> rf_wen = 0 in N+1; rf_waddr/rf_wdata hold last values.
REQ-023 Scoreboard: busy vector, 2**ADDR_WIDTH bits; busy[0] constantly 0.
REQ-024 iss_valid with iss_rd != 0 sets busy[iss_rd] at the clock edge.
REQ-025 busy[rf_waddr] clears at the edge ending the cycle in which rf_wen = 1, the same edge at which the register file captures the data.
REQ-026 Set and clear to the same index at the same edge: set wins (newer producer in flight).
REQ-027 rs1_busy = busy[rs1], rs2_busy = busy[rs2]; no bypass from rf_wdata.
REQ-028 Requester holding wb_valid without grant keeps wb_addr/wb_data stable; the block does not latch un-granted requests.

Reset
REQ-029 rst_n low asynchronously forces: ptr = 0, busy all 0, rf_wen = 0, rf_waddr = 0, rf_wdata = 0.
REQ-030 While rst_n is low, wb_ready = 0 regardless of wb_valid.
REQ-031 Reset mid-operation discards any grant from the prior cycle; rf_wen stays 0 in the first cycle after release.
REQ-032 After release, the first grant follows priority order 0, 1, 2.

Verification
REQ-033 Single request: wb_valid=3'b010, addr 5, data 0xAB -> wb_ready=3'b010 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xAB.
REQ-034 All three valid continuously after reset -> grants 0,1,2,0,1,2 over six cycles; rf_wen=1 on six consecutive cycles.
REQ-035 x0 write: EXU valid, addr 0, data 0xFF -> wb_ready[0]=1; next cycle rf_wen=0.
REQ-036 Scoreboard: iss_valid, iss_rd=7, then rs1=7 -> rs1_busy=1 until LSU writeback to 7 is driven on rf_wen; rs1_busy=0 the cycle after.
REQ-037 Same-edge set/clear: rf_wen=1 to index 3 while iss_valid with iss_rd=3 -> rs2=3 gives rs2_busy=1 afterward.
REQ-038 Reset pulse while CSR granted -> wb_ready=0 during reset; busy all 0, ptr=0, rf_wen=0 after release.
